// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM encoding for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULU = 2'b00;
   localparam logic [1:0] OP_MUL  = 2'b01;
   localparam logic [1:0] OP_DIVU = 2'b10;
   localparam logic [1:0] OP_DIV  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div_i,
   input  logic [2*WIDTH:0]   acc_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH:0]   acc_o
);

   logic [2*WIDTH:0] sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   sum;

   always_comb begin
      sh    = '0;
      diff  = '0;
      sum   = '0;
      acc_o = acc_i;
      if (is_div_i) begin
         sh    = {acc_i[2*WIDTH-1:0], 1'b0};
         diff  = sh[2*WIDTH:WIDTH] - {1'b0, b_i};
         acc_o = sh;
         // Bit WIDTH of diff is the borrow: set means trial subtract failed.
         if (!diff[WIDTH]) begin
            acc_o[2*WIDTH:WIDTH] = diff;
            acc_o[0]             = 1'b1;
         end
      end else begin
         sum   = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, b_i} : '0);
         acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative signed/unsigned multiply/divide, one step per clock.
module iter_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             z,
   output logic             n,
   output logic             v
);

   state_e             state_q, state_d;
   logic [1:0]         op_q;
   logic               sq_q, sr_q, ovf_q, dz_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH:0]   acc_q, acc_step;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
   logic               z_q, n_q, v_q, done_q;
   logic               z_d, v_d;

   logic               a_neg, b_neg, div_zero, ovf;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem;

   assign a_neg    = op[0] & a[WIDTH-1];
   assign b_neg    = op[0] & b[WIDTH-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;
   assign div_zero = op[1] & (b == '0);
   assign ovf      = (op == OP_DIV) & (&b)
                   & (a == {1'b1, {(WIDTH-1){1'b0}}});

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (op_q[1]),
      .acc_i    (acc_q),
      .b_i      (b_q),
      .acc_o    (acc_step)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = div_zero ? S_FIX : S_RUN;
         S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      prod = sq_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
      quot = sq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem  = sr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      hi_d = '0;
      lo_d = '0;
      z_d  = 1'b0;
      v_d  = 1'b0;
      if (dz_q) begin
         // Divide by zero skipped RUN; raw dividend still sits in acc.
         hi_d = acc_q[WIDTH-1:0];
         lo_d = '1;
         v_d  = 1'b1;
      end else if (op_q[1]) begin
         hi_d = rem;
         lo_d = quot;
         z_d  = (quot == '0);
         v_d  = ovf_q;
      end else begin
         hi_d = prod[2*WIDTH-1:WIDTH];
         lo_d = prod[WIDTH-1:0];
         z_d  = (acc_q == '0);
         v_d  = op_q[0] ? (hi_d != {WIDTH{lo_d[WIDTH-1]}})
                        : (hi_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         sq_q   <= 1'b0;
         sr_q   <= 1'b0;
         ovf_q  <= 1'b0;
         dz_q   <= 1'b0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         z_q    <= 1'b0;
         n_q    <= 1'b0;
         v_q    <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == S_FIX);
         unique case (state_q)
            S_IDLE: if (start) begin
               op_q  <= op;
               sq_q  <= a_neg ^ b_neg;
               sr_q  <= a_neg;
               ovf_q <= ovf;
               dz_q  <= div_zero;
               b_q   <= b_mag;
               acc_q <= {{(WIDTH+1){1'b0}}, div_zero ? a : a_mag};
               cnt_q <= '0;
            end
            S_RUN: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CW'(1);
            end
            S_FIX: begin
               hi_q <= hi_d;
               lo_q <= lo_d;
               z_q  <= z_d;
               n_q  <= lo_d[WIDTH-1];
               v_q  <= v_d;
            end
            default: ;
         endcase
      end
   end

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign z    = z_q;
   assign n    = n_q;
   assign v    = v_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: vector table plus handshake corner cases.
module tb_iter_muldiv;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         busy, done, z, n, v;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      logic         z, n, v;
      int           lat;
   } vec_t;

   vec_t vt[12];

   iter_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .z     (z),
      .n     (n),
      .v     (v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Call #1 after a posedge: this cycle becomes cycle 0.
   task automatic go(input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
   endtask

   task automatic wait_done(input int pulse_cyc, input logic [W-1:0] prev_lo,
                            output int lat, output bit busy_ok,
                            output bit hold_ok);
      lat     = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         lat++;
         start = 1'b0;
         if (lat == pulse_cyc) begin
            start = 1'b1;
            op    = OP_DIVU;
            a     = 32'd9;
            b     = 32'd3;
         end
         if (done) break;
         if (!busy) busy_ok = 1'b0;
         if (lo !== prev_lo) hold_ok = 1'b0;
      end
      if (busy) busy_ok = 1'b0;
   endtask

   int            lat, dn;
   bit            bok, hok;
   logic [W-1:0]  prev;

   initial begin
      vt[0]  = '{OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b1, 34};
      vt[1]  = '{OP_MUL,  32'hFFFFFFFD, 32'd7,
                 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0, 34};
      vt[2]  = '{OP_DIV,  32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 34};
      vt[3]  = '{OP_DIVU, 32'd100, 32'd7,
                 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 34};
      vt[4]  = '{OP_DIVU, 32'd100, 32'd0,
                 32'd100, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 2};
      vt[5]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF,
                 32'h0, 32'h80000000, 1'b0, 1'b1, 1'b1, 34};
      vt[6]  = '{OP_MULU, 32'd0, 32'd5,
                 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 34};
      vt[7]  = '{OP_MUL,  32'h00010000, 32'h00010000,
                 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 34};
      vt[8]  = '{OP_DIV,  32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 34};
      vt[9]  = '{OP_DIV,  32'hFFFFFFFB, 32'd0,
                 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 2};
      vt[10] = '{OP_MUL,  32'h80000000, 32'h80000000,
                 32'h40000000, 32'h0, 1'b0, 1'b0, 1'b1, 34};
      vt[11] = '{OP_DIVU, 32'hFFFFFFFF, 32'h10,
                 32'hF, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0, 34};

      rst   = 1'b1;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_z", z, 0);
      chk("rst_n", n, 0);
      chk("rst_v", v, 0);
      rst = 1'b0;

      prev = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         go(vt[i].op, vt[i].a, vt[i].b);
         wait_done(-1, prev, lat, bok, hok);
         chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
         chk($sformatf("v%0d_busy", i), bok, 1);
         chk($sformatf("v%0d_hold", i), hok, 1);
         chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
         chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
         chk($sformatf("v%0d_z", i), z, vt[i].z);
         chk($sformatf("v%0d_n", i), n, vt[i].n);
         chk($sformatf("v%0d_v", i), v, vt[i].v);
         prev = vt[i].lo;
      end

      // Ignored start mid-run, then back-to-back start in the done cycle.
      @(posedge clk);
      #1;
      go(OP_MULU, 32'd6, 32'd7);
      wait_done(5, prev, lat, bok, hok);
      chk("ign_lat", lat, 34);
      chk("ign_hold", hok, 1);
      chk("ign_lo", lo, 42);
      chk("ign_hi", hi, 0);
      go(OP_MULU, 32'd3, 32'd5);
      wait_done(-1, 32'd42, lat, bok, hok);
      chk("b2b_lat", lat, 34);
      chk("b2b_busy", bok, 1);
      chk("b2b_lo", lo, 15);

      // Abort via reset in cycle 10.
      @(posedge clk);
      #1;
      go(OP_DIV, 32'hFFFFFF9C, 32'd3);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (c == 10) begin
            chk("abort_busy10", busy, 1);
            rst = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      dn = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      chk("abort_nodone", dn, 0);
      go(OP_DIVU, 32'd100, 32'd7);
      wait_done(-1, 32'd0, lat, bok, hok);
      chk("post_lat", lat, 34);
      chk("post_lo", lo, 14);
      chk("post_hi", hi, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit. It is the iterative companion to the single-cycle ALU in the multi-cycle MIPS datapath.
- Performs signed/unsigned multiply and divide over WIDTH bits using one shift-add / shift-subtract step per clock.
- Exposes a start/busy/done handshake so the controller FSM stalls in a wait state until done.
- Results are held in hi/lo output registers for the datapath to read through the existing register-write mux.

Parameters:
- WIDTH, 32, operand and result width; legal range 4..64.
- CW, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in progress (RUN or FIX).
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- hi  out  WIDTH  multiply: upper product half; divide: remainder.
- lo  out  WIDTH  multiply: lower product half; divide: quotient.
- z  out  1  multiply: {hi,lo}==0; divide: lo==0.
- n  out  1  lo[WIDTH-1].
- v  out  1  multiply: product does not fit in WIDTH bits; divide: divide-by-zero or signed overflow.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=lo=0, z=0, n=0, v=0, counter=0. Reset asserted mid-operation aborts immediately; no done is produced.
- FSM states are IDLE, RUN and FIX.
  - IDLE: when start=1, capture op, |a| and |b| (magnitudes for signed ops) and the operand signs, clear the partial result, counter=0, go to RUN, busy=1.
  - RUN: one iteration per edge (restoring divide or shift-add multiply); counter increments. After the WIDTH-th iteration, go to FIX.
  - FIX: apply sign correction, then register hi/lo/z/n/v, pulse done=1, busy=0, and return to IDLE.
- Latency: if start is high in cycle 0, done is high in cycle WIDTH+2 (cycle 34 for WIDTH=32). busy is high in cycles 1..WIDTH+1.
- Divide by zero (op[1]=1, b==0): IDLE goes straight to FIX, so done is high in cycle 2.
  - Result: lo=all ones, hi=a, v=1.
- Signed rules:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - Product is negated if the operand signs differ.
- Signed overflow: DIV with a=most-negative and b=-1 gives lo=most-negative, hi=0, v=1.
- Multiply v:
  - MULU: v=(hi!=0).
  - MUL: v=(hi != replicate(lo[WIDTH-1])).
- Operands and op are captured at start. Changes to a/b/op while busy are ignored.
- start while busy is ignored and not queued.
- start in the same cycle as done is accepted, because the FSM is already in IDLE.
- hi/lo/z/n/v hold their values until the next FIX; they do not change during RUN.
- Width rule: internal accumulator is 2*WIDTH+1 bits. No truncation before FIX.

Decomposition:
- Shared package muldiv_pkg holds:
  - op code localparams (OP_MULU, OP_MUL, OP_DIVU, OP_DIV);
  - state encoding (S_IDLE, S_RUN, S_FIX).
- One combinational sub-module, muldiv_step, is natural: a single iteration of the shift-add / shift-subtract datapath, parametrised by WIDTH.
- FSM, counter and sign fix-up stay in iter_muldiv.

Test Plan (WIDTH=32):
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF, start in cycle 0 -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001, v=1, z=0.
- MUL a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, n=1, v=0; busy high in cycles 1..33.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 -> done in cycle 2; lo=0xFFFFFFFF, hi=100, v=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, v=1.
- Start a MULU 6*7; pulse start with a different op in cycle 5 -> ignored; result is lo=42. A new start in the done cycle is accepted and completes 34 cycles later.
- Start a DIV; assert rst in cycle 10 -> from cycle 11, busy=0, done=0, hi=lo=0, and no done pulse follows. The next start completes normally.
